// File: rtl/task_host.sv
// task_host: command FIFO plus launch/capture FSM driving the task-4 unit.
// Optional job watchdog is compiled in when TASK_HOST_WATCHDOG_EN is defined.
module task_host #(
  parameter int DEPTH     = 4,
  parameter int RUN_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [1:0] cmd_on,
  output logic [7:0] x,
  output logic [1:0] on,
  output logic       start,
  input  logic       active,
  input  logic [1:0] regime,
  input  logic [7:0] y,
  input  logic [2:0] s,
  input  logic       b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic [2:0] res_s,
  output logic       res_b,
  output logic [1:0] res_regime,
  output logic       res_err,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACT, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, full, empty;
  logic [7:0]    x_q, x_d;
  logic [1:0]    on_q, on_d;
  logic          start_q, start_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_y_q, res_y_d;
  logic [2:0]    res_s_q, res_s_d;
  logic          res_b_q, res_b_d;
  logic [1:0]    res_regime_q, res_regime_d;
  logic          capture, wd_err;
  logic          wait_expire, run_expire;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_on, cmd_x};
  end

  // Operands only change on the IDLE->LAUNCH edge, so they are stable while the unit runs.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    on_d         = on_q;
    pop          = 1'b0;
    capture      = 1'b0;
    wd_err       = 1'b0;
    res_valid_d  = res_valid_q;
    res_y_d      = res_y_q;
    res_s_d      = res_s_q;
    res_b_d      = res_b_q;
    res_regime_d = res_regime_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !res_valid_q) begin
          state_d      = LAUNCH;
          pop          = 1'b1;
          {on_d, x_d}  = mem_q[rd_ptr_q];
        end
      end
      LAUNCH: state_d = WAIT_ACT;
      WAIT_ACT: begin
        if (active) begin
          state_d = RUN;
        end else if (wait_expire) begin
          state_d = DONE;
          wd_err  = 1'b1;
        end
      end
      RUN: begin
        if (!active) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (run_expire) begin
          state_d = DONE;
          wd_err  = 1'b1;
        end
      end
      DONE: begin
        if (res_valid_q && res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      res_valid_d  = 1'b1;
      res_y_d      = y;
      res_s_d      = s;
      res_b_d      = b;
      res_regime_d = regime;
    end else if (wd_err) begin
      res_valid_d  = 1'b1;
      res_y_d      = '0;
      res_s_d      = '0;
      res_b_d      = 1'b0;
      res_regime_d = '0;
    end
    start_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      x_q          <= '0;
      on_q         <= '0;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_y_q      <= '0;
      res_s_q      <= '0;
      res_b_q      <= 1'b0;
      res_regime_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      x_q          <= x_d;
      on_q         <= on_d;
      start_q      <= start_d;
      res_valid_q  <= res_valid_d;
      res_y_q      <= res_y_d;
      res_s_q      <= res_s_d;
      res_b_q      <= res_b_d;
      res_regime_q <= res_regime_d;
    end
  end

`ifdef TASK_HOST_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       res_err_q, res_err_d;

  // Counter restarts on every state change, so it measures time spent in the current wait state.
  always_comb begin
    wd_cnt_d = '0;
    if (state_d == state_q && (state_q == WAIT_ACT || state_q == RUN))
      wd_cnt_d = wd_cnt_q + 8'd1;
    res_err_d = res_err_q;
    if (capture) res_err_d = 1'b0;
    if (wd_err)  res_err_d = 1'b1;
  end

  assign wait_expire = (wd_cnt_q == 8'd7);
  assign run_expire  = (wd_cnt_q >= 8'(RUN_LIMIT));
  assign res_err     = res_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      res_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      res_err_q <= res_err_d;
    end
  end
`else
  assign wait_expire = 1'b0;
  assign run_expire  = 1'b0;
  assign res_err     = 1'b0;
`endif

  assign x          = x_q;
  assign on         = on_q;
  assign start      = start_q;
  assign res_valid  = res_valid_q;
  assign res_y      = res_y_q;
  assign res_s      = res_s_q;
  assign res_b      = res_b_q;
  assign res_regime = res_regime_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_task_host.sv
// Bench for task_host: directed scenarios plus a randomized phase scored against
// a queue-based command/result model and a behavioural unit model.
module tb_task_host;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_x;
  logic [1:0] cmd_on;
  logic [7:0] x;
  logic [1:0] on;
  logic       start, active;
  logic [1:0] regime;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic       res_valid, res_ready;
  logic [7:0] res_y;
  logic [2:0] res_s;
  logic       res_b;
  logic [1:0] res_regime;
  logic       res_err, busy;

  always #5 clk = ~clk;

  task_host #(.DEPTH(DEPTH), .RUN_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_on(cmd_on), .x(x), .on(on), .start(start),
    .active(active), .regime(regime), .y(y), .s(s), .b(b),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_s(res_s),
    .res_b(res_b), .res_regime(res_regime), .res_err(res_err), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int launches = 0;
  logic [9:0]  exp_cmd [$];
  logic [14:0] res_exp [$];

  bit         hold_active = 0, no_rise = 0, rand_timing = 1, rand_res = 1;
  int         u_delay = 0, u_len = 3;
  logic [7:0] u_y = '0;
  logic [2:0] u_s = '0;
  logic       u_b = 1'b0;
  logic [1:0] u_regime = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cx, input logic [1:0] co);
    logic ok;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_x     = cx;
    cmd_on    = co;
    do begin
      ok = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) checkOutput("push_timeout", ok, 1);
  endtask

  task automatic waitResult(input int limit);
    int n;
    n = 0;
    while (!res_valid && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("res_timeout", res_valid, 1);
  endtask

  task automatic waitIdle();
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 600) begin
      @(posedge clk); #1;
      n++;
      done = !busy && !res_valid && !active && exp_cmd.size() == 0;
    end
    checkOutput("idle_timeout", done, 1);
  endtask

  // Unit model: active rises one or more cycles after start, result appears as active falls.
  initial begin : unit_model
    int d, l;
    active = 1'b0; y = '0; s = '0; b = 1'b0; regime = '0;
    forever begin
      @(posedge clk); #2;
      if (rst && start) begin
        if (no_rise) begin
`ifdef TASK_HOST_WATCHDOG_EN
          res_exp.push_back(15'h0001);
`endif
        end else begin
          d = rand_timing ? int'($urandom_range(0, 3)) : u_delay;
          l = rand_timing ? int'($urandom_range(1, 6)) : u_len;
          @(posedge clk); #2;
          for (int i = 0; i < d && rst; i++) begin @(posedge clk); #2; end
          if (rst) begin
            active = 1'b1;
            regime = 2'($urandom);
            for (int i = 0; (i < l || hold_active) && rst; i++) begin @(posedge clk); #2; end
            if (rst) begin
              if (rand_res) begin
                y = 8'($urandom); s = 3'($urandom); b = 1'($urandom); regime = 2'($urandom);
              end else begin
                y = u_y; s = u_s; b = u_b; regime = u_regime;
              end
              res_exp.push_back({y, s, b, regime, 1'b0});
            end
            active = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: commands must launch in acceptance order, results must match the unit's output.
  initial begin : monitor
    logic prev_start, prev_rv;
    logic [9:0]  last_cmd, c;
    logic [14:0] r;
    prev_start = 1'b0; prev_rv = 1'b0; last_cmd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_cmd.delete();
        res_exp.delete();
        prev_start = 1'b0; prev_rv = 1'b0; last_cmd = '0;
      end else begin
        if (start) begin
          launches++;
          checkOutput("start_pulse", prev_start, 0);
          checkOutput("start_vs_res", res_valid, 0);
          if (exp_cmd.size() == 0) checkOutput("start_unexpected", start, 0);
          else begin
            c = exp_cmd.pop_front();
            checkOutput("launch_cmd", {on, x}, c);
            last_cmd = c;
          end
        end
        if (active) checkOutput("operand_stable", {on, x}, last_cmd);
        checkOutput("cmd_ready", cmd_ready, exp_cmd.size() < DEPTH);
        if (cmd_valid && cmd_ready) exp_cmd.push_back({cmd_on, cmd_x});
        if (res_valid && !prev_rv) begin
          if (res_exp.size() == 0) checkOutput("res_unexpected", res_valid, 0);
          else begin
            r = res_exp.pop_front();
            checkOutput("result", {res_y, res_s, res_b, res_regime, res_err}, r);
          end
        end
        prev_start = start;
        prev_rv    = res_valid;
      end
    end
  end

  initial begin : main
    int base;
    rst = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_on = '0; res_ready = 1'b0;
    #12;
    checkOutput("rst_x", x, 0);
    checkOutput("rst_on", on, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res", {res_y, res_s, res_b, res_regime, res_err}, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single job followed by back-pressure on the result slot.
    rand_timing = 0; rand_res = 0; u_delay = 0; u_len = 3;
    u_y = 8'hA5; u_s = 3'd4; u_b = 1'b1; u_regime = 2'd2;
    applyStimulus(8'h5A, 2'b01);
    cmd_valid = 1'b0;
    checkOutput("start_n1", start, 0);
    @(posedge clk); #1;
    checkOutput("start_n2", start, 1);
    checkOutput("launch_x", x, 8'h5A);
    checkOutput("launch_on", on, 2'b01);
    applyStimulus(8'h33, 2'b10);
    cmd_valid = 1'b0;
    waitResult(100);
    checkOutput("res_y", res_y, 8'hA5);
    checkOutput("res_s", res_s, 3'd4);
    checkOutput("res_b", res_b, 1);
    checkOutput("res_regime", res_regime, 2'd2);
    checkOutput("res_err", res_err, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_no_start", start, 0);
      checkOutput("bp_hold", res_valid, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_start_1", start, 0);
    @(posedge clk); #1;
    checkOutput("bp_start_2", start, 1);
    checkOutput("bp_x", x, 8'h33);
    waitIdle();

    // FIFO fill against a stalled unit and a blocked result slot.
    res_ready = 1'b0; hold_active = 1; rand_res = 1; u_len = 1;
    base = launches;
    for (int i = 0; i < 5; i++) applyStimulus(8'(16 + i), 2'(i));
    cmd_x = 8'hEE;
    checkOutput("full_ready", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("full_hold", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    checkOutput("full_launches", launches - base, 1);
    checkOutput("full_x_head", x, 8'h10);
    hold_active = 0; res_ready = 1'b1;
    waitIdle();
    checkOutput("full_all_launched", launches - base, 5);

    // Operands held during a long active window while new commands arrive.
    u_len = 20;
    applyStimulus(8'hC3, 2'b11);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 2'($urandom));
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (active) checkOutput("stab_x_on", {on, x}, {2'b11, 8'hC3});
      @(posedge clk); #1;
    end
    waitIdle();

    // Randomized traffic.
    rand_timing = 1; rand_res = 1;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_x     = 8'($urandom);
      cmd_on    = 2'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    waitIdle();

    // Asynchronous reset while a job is in RUN with another queued.
    rand_timing = 0; u_delay = 0; u_len = 1; hold_active = 1;
    applyStimulus(8'h77, 2'b01);
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", busy, 1);
    applyStimulus(8'h88, 2'b00);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_start", start, 0);
    checkOutput("arst_res_valid", res_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_cmd_ready", cmd_ready, 1);
    checkOutput("arst_x", x, 0);
    hold_active = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("post_reset_empty", busy, 0);
    end
    applyStimulus(8'h3C, 2'b10);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_start", start, 1);
    checkOutput("post_reset_x", x, 8'h3C);
    waitIdle();

    // Unit that never becomes active.
    no_rise = 1; res_ready = 1'b1;
    applyStimulus(8'h99, 2'b10);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("wd_start", start, 1);
`ifdef TASK_HOST_WATCHDOG_EN
    waitResult(12);
    checkOutput("wd_err", res_err, 1);
    checkOutput("wd_res_y", res_y, 0);
    waitIdle();
`else
    repeat (50) @(posedge clk);
    #1;
    checkOutput("nowd_busy", busy, 1);
    checkOutput("nowd_res_valid", res_valid, 0);
    checkOutput("nowd_res_err", res_err, 0);
`endif
    checkOutput("res_queue_drained", res_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
